// File: rtl/coco_mem_responder.sv
// On-chip RAM target for the Coco CPU memory port: wait-stated word RAM with
// byte-lane writes, out-of-window accesses completed as bus errors.
module coco_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [29:0] A,
  input  logic [3:0]  BE,
  input  logic [31:0] WData,
  input  logic        RW,
  input  logic        Req,
  output logic [31:0] RData,
  output logic        Ready,
  output logic        BusErr,
  output logic [29:0] ErrAddr,
  output logic        Busy
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [29:0]        a_q;
  logic [3:0]         be_q;
  logic [31:0]        wd_q;
  logic               rw_q;
  logic [31:0]        mem [DEPTH];

  logic                  hit_c;
  logic                  commit_c;
  logic [ADDR_WIDTH-1:0] idx_c;

  // Window match on the word-address bits above the RAM index
  assign hit_c    = (a_q[29:ADDR_WIDTH] == BASE[31:ADDR_WIDTH+2]);
  assign idx_c    = a_q[ADDR_WIDTH-1:0];
  assign commit_c = (state == S_WAIT) && Req && (cnt == '0);

  // RAM array is deliberately not reset; writes only on a committing hit
  always_ff @(posedge Clk) begin
    if (commit_c && hit_c && !rw_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_c][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_q     <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rw_q    <= 1'b0;
      RData   <= '0;
      Ready   <= 1'b0;
      BusErr  <= 1'b0;
      ErrAddr <= '0;
      Busy    <= 1'b0;
    end else begin
      Ready  <= 1'b0;
      BusErr <= 1'b0;
      RData  <= '0;
      case (state)
        S_IDLE: begin
          if (Req) begin
            a_q   <= A;
            be_q  <= BE;
            wd_q  <= WData;
            rw_q  <= RW;
            cnt   <= CNT_W'(WAIT_CYCLES);
            state <= S_WAIT;
            Busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!Req) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            Ready <= 1'b1;
            state <= S_RESP;
            if (hit_c) begin
              if (rw_q) RData <= mem[idx_c];
            end else begin
              BusErr  <= 1'b1;
              ErrAddr <= a_q;
            end
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
